// File: rtl/alu_pkg.sv
// Shared encodings, FSM state type and small helpers for the alu_md execute unit.
// Base-op codes keep the legacy 3-bit ALU values with a zero MSB.
package alu_pkg;

    localparam logic [3:0] CTRL_SUM    = 4'b0000;
    localparam logic [3:0] CTRL_SUB    = 4'b0001;
    localparam logic [3:0] CTRL_AND    = 4'b0010;
    localparam logic [3:0] CTRL_OR     = 4'b0011;
    localparam logic [3:0] CTRL_SRCB   = 4'b0100;
    localparam logic [3:0] CTRL_LT     = 4'b0101;
    localparam logic [3:0] CTRL_LTU    = 4'b0110;
    localparam logic [3:0] CTRL_XOR    = 4'b0111;
    localparam logic [3:0] CTRL_MUL    = 4'b1000;
    localparam logic [3:0] CTRL_MULH   = 4'b1001;
    localparam logic [3:0] CTRL_MULHSU = 4'b1010;
    localparam logic [3:0] CTRL_MULHU  = 4'b1011;
    localparam logic [3:0] CTRL_DIV    = 4'b1100;
    localparam logic [3:0] CTRL_DIVU   = 4'b1101;
    localparam logic [3:0] CTRL_REM    = 4'b1110;
    localparam logic [3:0] CTRL_REMU   = 4'b1111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } state_e;

    // Ops whose lt flag compares the operands as unsigned values.
    function automatic logic is_unsigned_op(input logic [3:0] ctrl);
        return (ctrl == CTRL_LTU) || (ctrl == CTRL_MULHU) ||
               (ctrl == CTRL_DIVU) || (ctrl == CTRL_REMU);
    endfunction

endpackage

// File: rtl/md_iter_core.sv
// Unsigned iterative engine: WIDTH shift-add multiply steps or WIDTH restoring divide steps.
// Multiply leaves the product in {hi_o, lo_o}; divide leaves remainder in hi_o, quotient in lo_o.
module md_iter_core #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             step,
    input  logic             is_div,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o
);

    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             div_q, div_d;

    logic [WIDTH:0]   add_sum;
    logic [WIDTH:0]   shifted;
    logic [WIDTH-1:0] diff;
    logic             ge;

    always_ff @(posedge clk) begin
        if (rst) begin
            hi_q  <= '0;
            lo_q  <= '0;
            b_q   <= '0;
            div_q <= 1'b0;
        end else begin
            hi_q  <= hi_d;
            lo_q  <= lo_d;
            b_q   <= b_d;
            div_q <= div_d;
        end
    end

    always_comb begin
        hi_d  = hi_q;
        lo_d  = lo_q;
        b_d   = b_q;
        div_d = div_q;
        add_sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : '0);
        // Partial remainder stays below the divisor, so the shifted value fits in WIDTH+1 bits.
        shifted = {hi_q, lo_q[WIDTH-1]};
        ge      = (shifted >= {1'b0, b_q});
        diff    = shifted[WIDTH-1:0] - b_q;
        if (load) begin
            hi_d  = '0;
            lo_d  = a_in;
            b_d   = b_in;
            div_d = is_div;
        end else if (step) begin
            if (div_q) begin
                hi_d = ge ? diff : shifted[WIDTH-1:0];
                lo_d = {lo_q[WIDTH-2:0], ge};
            end else begin
                hi_d = add_sum[WIDTH:1];
                lo_d = {add_sum[0], lo_q[WIDTH-1:1]};
            end
        end
    end

    assign hi_o = hi_q;
    assign lo_o = lo_q;

endmodule

// File: rtl/alu_md.sv
// EX-stage ALU with RV32M extension: base ops finish in one cycle, M ops take a fixed
// WIDTH+2 cycles through an IDLE/CALC/FIX sequence with a start/busy/done handshake.
module alu_md
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [3:0]       Ctrl,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] Res,
    output logic             Zero,
    output logic             lt,
    output logic             busy,
    output logic             done
);

    localparam int CNT_W = $clog2(WIDTH) + 1;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       op_q, op_d;
    logic             neg_q, neg_d;
    logic             divz_q, divz_d;
    logic             lt_pend_q, lt_pend_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             zero_q, zero_d;
    logic             lt_q, lt_d;
    logic             done_q, done_d;

    logic             accept;
    logic             core_load, core_step;
    logic             sa, sb, neg_in, lt_in;
    logic [WIDTH-1:0] mag_a, mag_b;
    logic [WIDTH-1:0] base_res, md_res;
    logic [WIDTH-1:0] core_hi, core_lo;
    logic [2*WIDTH-1:0] prod_raw, prod;

    assign accept = start && (state_q == IDLE);

    md_iter_core #(.WIDTH(WIDTH)) u_core (
        .clk    (clk),
        .rst    (rst),
        .load   (core_load),
        .step   (core_step),
        .is_div (Ctrl[2]),
        .a_in   (mag_a),
        .b_in   (mag_b),
        .hi_o   (core_hi),
        .lo_o   (core_lo)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            op_q      <= '0;
            neg_q     <= 1'b0;
            divz_q    <= 1'b0;
            lt_pend_q <= 1'b0;
            a_q       <= '0;
            res_q     <= '0;
            zero_q    <= 1'b1;
            lt_q      <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            op_q      <= op_d;
            neg_q     <= neg_d;
            divz_q    <= divz_d;
            lt_pend_q <= lt_pend_d;
            a_q       <= a_d;
            res_q     <= res_d;
            zero_q    <= zero_d;
            lt_q      <= lt_d;
            done_q    <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (accept && Ctrl[3]) begin
                    state_d = CALC;
                    cnt_d   = CNT_W'(WIDTH);
                end
            end
            CALC: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = FIX;
                end
            end
            FIX:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Operand conditioning: the core sees magnitudes, the sign of the result is kept aside.
    always_comb begin
        sa = A[WIDTH-1] && ((Ctrl == CTRL_MULH) || (Ctrl == CTRL_MULHSU) ||
                            (Ctrl == CTRL_DIV)  || (Ctrl == CTRL_REM));
        sb = B[WIDTH-1] && ((Ctrl == CTRL_MULH) || (Ctrl == CTRL_DIV) ||
                            (Ctrl == CTRL_REM));
        mag_a  = sa ? -A : A;
        mag_b  = sb ? -B : B;
        neg_in = (Ctrl == CTRL_REM) ? sa : (sa ^ sb);
        lt_in  = is_unsigned_op(Ctrl) ? (A < B) : ($signed(A) < $signed(B));
    end

    always_comb begin
        case (Ctrl)
            CTRL_SUM:  base_res = A + B;
            CTRL_SUB:  base_res = A - B;
            CTRL_AND:  base_res = A & B;
            CTRL_OR:   base_res = A | B;
            CTRL_LT:   base_res = {{(WIDTH-1){1'b0}}, $signed(A) < $signed(B)};
            CTRL_LTU:  base_res = {{(WIDTH-1){1'b0}}, A < B};
            CTRL_XOR:  base_res = A ^ B;
            CTRL_SRCB: base_res = B;
            default:   base_res = B;
        endcase
    end

    // Divide-by-zero bypasses sign correction; signed overflow falls out of the magnitude path.
    always_comb begin
        prod_raw = {core_hi, core_lo};
        prod     = neg_q ? -prod_raw : prod_raw;
        case (op_q)
            CTRL_MUL:                            md_res = prod[WIDTH-1:0];
            CTRL_MULH, CTRL_MULHSU, CTRL_MULHU:  md_res = prod[2*WIDTH-1:WIDTH];
            CTRL_DIV, CTRL_DIVU:                 md_res = divz_q ? '1 : (neg_q ? -core_lo : core_lo);
            CTRL_REM, CTRL_REMU:                 md_res = divz_q ? a_q : (neg_q ? -core_hi : core_hi);
            default:                             md_res = prod[WIDTH-1:0];
        endcase
    end

    always_comb begin
        res_d     = res_q;
        zero_d    = zero_q;
        lt_d      = lt_q;
        done_d    = 1'b0;
        op_d      = op_q;
        neg_d     = neg_q;
        divz_d    = divz_q;
        a_d       = a_q;
        lt_pend_d = lt_pend_q;
        core_load = 1'b0;
        core_step = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (!Ctrl[3]) begin
                        res_d  = base_res;
                        zero_d = (base_res == '0);
                        lt_d   = lt_in;
                        done_d = 1'b1;
                    end else begin
                        core_load = 1'b1;
                        op_d      = Ctrl;
                        neg_d     = neg_in;
                        divz_d    = (B == '0);
                        a_d       = A;
                        lt_pend_d = lt_in;
                    end
                end
            end
            CALC: core_step = 1'b1;
            FIX: begin
                res_d  = md_res;
                zero_d = (md_res == '0);
                lt_d   = lt_pend_q;
                done_d = 1'b1;
            end
            default: ;
        endcase
    end

    assign Res  = res_q;
    assign Zero = zero_q;
    assign lt   = lt_q;
    assign done = done_q;
    assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_alu_md.sv
// Self-checking bench for alu_md at WIDTH=32: directed scenarios plus random ops
// checked against an independent arithmetic model through an expected-result queue.
module tb_alu_md;
    import alu_pkg::*;

    localparam int W      = 32;
    localparam int MD_LAT = W + 2;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [3:0]   Ctrl;
    logic [W-1:0] A, B;
    logic [W-1:0] Res;
    logic         Zero, lt, busy, done;

    int n_vec  = 0;
    int n_miss = 0;

    logic [W-1:0] exp_q[$];
    logic         exp_lt_q[$];

    alu_md #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .Ctrl  (Ctrl),
        .A     (A),
        .B     (B),
        .Res   (Res),
        .Zero  (Zero),
        .lt    (lt),
        .busy  (busy),
        .done  (done)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] model_res(input logic [3:0] c, input logic [31:0] a,
                                              input logic [31:0] b);
        longint      sa, sb, ua, ub;
        logic [63:0] p;
        logic [31:0] r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'({32'd0, a});
        ub = longint'({32'd0, b});
        p  = '0;
        r  = '0;
        case (c)
            4'h0: r = a + b;
            4'h1: r = a - b;
            4'h2: r = a & b;
            4'h3: r = a | b;
            4'h4: r = b;
            4'h5: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'h6: r = (a < b) ? 32'd1 : 32'd0;
            4'h7: r = a ^ b;
            4'h8: begin p = sa * sb; r = p[31:0]; end
            4'h9: begin p = sa * sb; r = p[63:32]; end
            4'hA: begin p = sa * ub; r = p[63:32]; end
            4'hB: begin p = ua * ub; r = p[63:32]; end
            4'hC: begin
                if (b == 32'd0) r = 32'hFFFF_FFFF;
                else begin p = sa / sb; r = p[31:0]; end
            end
            4'hD: r = (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
            4'hE: begin
                if (b == 32'd0) r = a;
                else begin p = sa % sb; r = p[31:0]; end
            end
            default: r = (b == 32'd0) ? a : a % b;
        endcase
        return r;
    endfunction

    function automatic logic model_lt(input logic [3:0] c, input logic [31:0] a,
                                      input logic [31:0] b);
        if (c == 4'h6 || c == 4'hB || c == 4'hD || c == 4'hF) return a < b;
        return $signed(a) < $signed(b);
    endfunction

    // Present a request at a negedge while the unit is idle; returns just after the accept edge.
    task automatic issue(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
        start = 1'b1;
        Ctrl  = c;
        A     = a;
        B     = b;
        @(posedge clk);
        #1;
        start = 1'b0;
        Ctrl  = 4'($urandom_range(0, 15));
        A     = $urandom;
        B     = $urandom;
    endtask

    // lat counts cycles after the accept edge; returns at the negedge of the done cycle.
    task automatic wait_done(output int lat);
        lat = 1;
        @(negedge clk);
        while (done !== 1'b1 && lat < 100) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic test_reset();
        int           lat;
        logic [W-1:0] e;
        logic         el;
        rst = 1'b1; start = 1'b0; Ctrl = '0; A = '0; B = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_vec++;
        if ({Res, Zero, lt, busy, done} !== {32'd0, 1'b1, 1'b0, 1'b0, 1'b0}) begin
            n_miss++;
            $display("FAIL reset_state: got Res=%h Zero=%b lt=%b busy=%b done=%b, expected Res=0 Zero=1 lt=0 busy=0 done=0",
                     Res, Zero, lt, busy, done);
        end
        rst = 1'b0;
        exp_q.push_back(32'd0);
        exp_lt_q.push_back(model_lt(CTRL_SUB, 32'd5, 32'd5));
        issue(CTRL_SUB, 32'd5, 32'd5);
        wait_done(lat);
        e  = exp_q.pop_front();
        el = exp_lt_q.pop_front();
        n_vec++;
        if (lat != 1) begin n_miss++; $display("FAIL sub_latency: got %0d, expected 1", lat); end
        n_vec++;
        if (Res !== e) begin n_miss++; $display("FAIL sub_res: got %h, expected %h", Res, e); end
        n_vec++;
        if (Zero !== 1'b1) begin n_miss++; $display("FAIL sub_zero: got %b, expected 1", Zero); end
        n_vec++;
        if (lt !== el) begin n_miss++; $display("FAIL sub_lt: got %b, expected %b", lt, el); end
        n_vec++;
        if (busy !== 1'b0) begin n_miss++; $display("FAIL sub_busy: got %b, expected 0", busy); end
    endtask

    task automatic test_div_signed();
        logic [3:0]   tc [2];
        logic [W-1:0] te [2];
        logic [W-1:0] e;
        logic         el;
        int           lat;
        tc = '{CTRL_DIV, CTRL_REM};
        te = '{32'hFFFF_FFFD, 32'hFFFF_FFFF};
        for (int i = 0; i < 2; i++) begin
            exp_q.push_back(te[i]);
            exp_lt_q.push_back(model_lt(tc[i], 32'hFFFF_FFF9, 32'd2));
            issue(tc[i], 32'hFFFF_FFF9, 32'd2);
            wait_done(lat);
            e  = exp_q.pop_front();
            el = exp_lt_q.pop_front();
            n_vec++;
            if (lat != MD_LAT) begin n_miss++; $display("FAIL sdiv_latency[%0d]: got %0d, expected %0d", i, lat, MD_LAT); end
            n_vec++;
            if (Res !== e) begin n_miss++; $display("FAIL sdiv_res[%0d]: got %h, expected %h", i, Res, e); end
            n_vec++;
            if (lt !== el) begin n_miss++; $display("FAIL sdiv_lt[%0d]: got %b, expected %b", i, lt, el); end
            n_vec++;
            if (busy !== 1'b0) begin n_miss++; $display("FAIL sdiv_busy_at_done[%0d]: got %b, expected 0", i, busy); end
        end
    endtask

    task automatic test_mulh();
        logic [3:0]   tc [4];
        logic [W-1:0] ta [4];
        logic [W-1:0] tb [4];
        logic [W-1:0] te [4];
        logic [W-1:0] e;
        logic         el;
        int           lat;
        tc = '{CTRL_MULH, CTRL_MULHU, CTRL_MULHSU, CTRL_MUL};
        ta = '{32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        tb = '{32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF};
        te = '{32'h4000_0000, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h0000_0001};
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back(te[i]);
            exp_lt_q.push_back(model_lt(tc[i], ta[i], tb[i]));
            issue(tc[i], ta[i], tb[i]);
            wait_done(lat);
            e  = exp_q.pop_front();
            el = exp_lt_q.pop_front();
            n_vec++;
            if (lat != MD_LAT) begin n_miss++; $display("FAIL mul_latency[%0d]: got %0d, expected %0d", i, lat, MD_LAT); end
            n_vec++;
            if (Res !== e) begin n_miss++; $display("FAIL mul_res[%0d]: got %h, expected %h", i, Res, e); end
            n_vec++;
            if (lt !== el) begin n_miss++; $display("FAIL mul_lt[%0d]: got %b, expected %b", i, lt, el); end
        end
    endtask

    task automatic test_div_special();
        logic [3:0]   tc [4];
        logic [W-1:0] ta [4];
        logic [W-1:0] tb [4];
        logic [W-1:0] te [4];
        logic [W-1:0] e;
        int           lat;
        tc = '{CTRL_DIVU, CTRL_REMU, CTRL_DIV, CTRL_REM};
        ta = '{32'd5, 32'd5, 32'h8000_0000, 32'h8000_0000};
        tb = '{32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        te = '{32'hFFFF_FFFF, 32'd5, 32'h8000_0000, 32'd0};
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back(te[i]);
            issue(tc[i], ta[i], tb[i]);
            wait_done(lat);
            e = exp_q.pop_front();
            n_vec++;
            if (lat != MD_LAT) begin n_miss++; $display("FAIL dspec_latency[%0d]: got %0d, expected %0d", i, lat, MD_LAT); end
            n_vec++;
            if (Res !== e) begin n_miss++; $display("FAIL dspec_res[%0d]: got %h, expected %h", i, Res, e); end
            n_vec++;
            if (Zero !== (e == '0)) begin n_miss++; $display("FAIL dspec_zero[%0d]: got %b, expected %b", i, Zero, e == '0); end
        end
    endtask

    task automatic test_handshake();
        logic [W-1:0] e;
        int           lat;
        logic         held, busy_ok;
        exp_q.push_back(32'd30);
        issue(CTRL_SUM, 32'd10, 32'd20);
        wait_done(lat);
        e = exp_q.pop_front();
        n_vec++;
        if (Res !== e) begin n_miss++; $display("FAIL hs_pre_res: got %h, expected %h", Res, e); end
        exp_q.push_back(32'd14);
        issue(CTRL_DIV, 32'd100, 32'd7);
        lat     = 1;
        held    = 1'b1;
        busy_ok = 1'b1;
        @(negedge clk);
        while (done !== 1'b1 && lat < 100) begin
            if (Res !== 32'd30) held = 1'b0;
            if (busy !== 1'b1) busy_ok = 1'b0;
            if (lat == 3) begin
                start = 1'b1; Ctrl = CTRL_SUM; A = 32'd1; B = 32'd1;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            lat++;
        end
        start = 1'b0;
        e = exp_q.pop_front();
        n_vec++;
        if (held !== 1'b1) begin n_miss++; $display("FAIL hs_res_held: got %b, expected 1", held); end
        n_vec++;
        if (busy_ok !== 1'b1) begin n_miss++; $display("FAIL hs_busy_during: got %b, expected 1", busy_ok); end
        n_vec++;
        if (lat != MD_LAT) begin n_miss++; $display("FAIL hs_latency: got %0d, expected %0d", lat, MD_LAT); end
        n_vec++;
        if (Res !== e) begin n_miss++; $display("FAIL hs_div_res: got %h, expected %h", Res, e); end
        @(negedge clk);
        n_vec++;
        if (done !== 1'b0) begin n_miss++; $display("FAIL hs_no_queued_op: got done=%b, expected 0", done); end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] e;
        int           lat;
        exp_q.push_back(32'd2);
        issue(CTRL_REMU, 32'd17, 32'd5);
        wait_done(lat);
        e = exp_q.pop_front();
        n_vec++;
        if (Res !== e) begin n_miss++; $display("FAIL b2b_remu_res: got %h, expected %h", Res, e); end
        exp_q.push_back(32'd3);
        issue(CTRL_SUM, 32'd1, 32'd2);
        wait_done(lat);
        e = exp_q.pop_front();
        n_vec++;
        if (lat != 1) begin n_miss++; $display("FAIL b2b_latency: got %0d, expected 1", lat); end
        n_vec++;
        if (Res !== e) begin n_miss++; $display("FAIL b2b_res: got %h, expected %h", Res, e); end
        @(negedge clk);
        n_vec++;
        if ({Res, done} !== {e, 1'b0}) begin n_miss++; $display("FAIL b2b_hold: got Res=%h done=%b, expected Res=%h done=0", Res, done, e); end
    endtask

    task automatic test_mid_reset();
        logic [W-1:0] e;
        int           lat;
        logic         saw_done;
        issue(CTRL_MUL, 32'd1234, 32'd5678);
        repeat (10) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_vec++;
        if ({Res, Zero, busy, done} !== {32'd0, 1'b1, 1'b0, 1'b0}) begin
            n_miss++;
            $display("FAIL midrst_state: got Res=%h Zero=%b busy=%b done=%b, expected Res=0 Zero=1 busy=0 done=0",
                     Res, Zero, busy, done);
        end
        saw_done = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (done === 1'b1) saw_done = 1'b1;
        end
        n_vec++;
        if (saw_done !== 1'b0) begin n_miss++; $display("FAIL midrst_no_done: got %b, expected 0", saw_done); end
        exp_q.push_back(32'hFFFF_FFFE);
        issue(CTRL_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_done(lat);
        e = exp_q.pop_front();
        n_vec++;
        if (lat != MD_LAT) begin n_miss++; $display("FAIL midrst_latency: got %0d, expected %0d", lat, MD_LAT); end
        n_vec++;
        if (Res !== e) begin n_miss++; $display("FAIL midrst_mulhu_res: got %h, expected %h", Res, e); end
    endtask

    task automatic test_random();
        logic [W-1:0] corner [5];
        logic [3:0]   c;
        logic [W-1:0] a, b, e;
        logic         el;
        int           lat, exp_lat;
        corner = '{32'd0, 32'd1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF};
        for (int i = 0; i < 24; i++) begin
            c = 4'($urandom_range(0, 15));
            a = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 4)] : $urandom;
            case ($urandom_range(0, 3))
                0:       b = corner[$urandom_range(0, 4)];
                1:       b = 32'($urandom_range(0, 9));
                default: b = $urandom;
            endcase
            exp_lat = c[3] ? MD_LAT : 1;
            exp_q.push_back(model_res(c, a, b));
            exp_lt_q.push_back(model_lt(c, a, b));
            issue(c, a, b);
            wait_done(lat);
            e  = exp_q.pop_front();
            el = exp_lt_q.pop_front();
            n_vec++;
            if (lat != exp_lat) begin n_miss++; $display("FAIL rnd_latency[%0d] op=%h: got %0d, expected %0d", i, c, lat, exp_lat); end
            n_vec++;
            if (Res !== e) begin n_miss++; $display("FAIL rnd_res[%0d] op=%h a=%h b=%h: got %h, expected %h", i, c, a, b, Res, e); end
            n_vec++;
            if (Zero !== (e == '0)) begin n_miss++; $display("FAIL rnd_zero[%0d]: got %b, expected %b", i, Zero, e == '0); end
            n_vec++;
            if (lt !== el) begin n_miss++; $display("FAIL rnd_lt[%0d] op=%h: got %b, expected %b", i, c, lt, el); end
        end
        n_vec++;
        if (exp_q.size() != 0) begin n_miss++; $display("FAIL queue_drained: got %0d entries, expected 0", exp_q.size()); end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_div_signed();
        test_mulh();
        test_div_special();
        test_handshake();
        test_back_to_back();
        test_mid_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/alu_md.md
Name: alu_md

Overview:
- Parametrised successor to the single-cycle datapath ALU. Executes the eight base ALU operations plus the RV32M multiply/divide/remainder set.
- Uses a start/busy/done handshake, so the multicycle controller can stall on long operations.
- Base ops complete in 1 cycle. M ops use an iterative shift-add multiplier and a restoring divider with fixed latency.
- Sits in the EX stage in place of the combinational ALU.

Parameters:
- WIDTH, 32, operand/result width in bits (>=4, even).
- CNT_W, $clog2(WIDTH)+1, iteration counter width (derived; not overridden).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request; operands and op sampled on the rising edge where start=1 and busy=0.
- Ctrl  in  4  operation code (alu_pkg encoding).
- A  in  WIDTH  operand A (rs1).
- B  in  WIDTH  operand B (rs2/imm).
- Res  out  WIDTH  registered result, valid while done=1, held until next completion.
- Zero  out  1  registered: Res==0, updated with Res.
- lt  out  1  registered: A<B (unsigned if Ctrl=LTU or MULHU/DIVU/REMU, else signed), updated with Res.
- busy  out  1  high while an M op is in flight.
- done  out  1  one-cycle completion pulse.

Behaviour:
- Reset (rst=1 at a rising edge, any state, including mid-operation): state=IDLE; Res=0, Zero=1, lt=0, busy=0, done=0; the in-flight op is discarded and its done is never asserted.
- Op codes:
  - 0000 SUM, 0001 SUB, 0010 AND, 0011 OR, 0100 SRCB, 0101 LT, 0110 LTU, 0111 XOR.
  - 1000 MUL, 1001 MULH, 1010 MULHSU, 1011 MULHU, 1100 DIV, 1101 DIVU, 1110 REM, 1111 REMU.
- Base ops (Ctrl[3]=0):
  - Accepted in IDLE; state stays IDLE.
  - At the accept edge, Res/Zero/lt are loaded and done is set. done=1 for exactly the following cycle (latency 1). busy stays 0.
  - Arithmetic is modulo 2^WIDTH. LT/LTU results are zero-extended to WIDTH.
- M ops (Ctrl[3]=1):
  - Accept edge t: latch operand magnitudes, result-sign flags, op; IDLE->CALC; busy=1; counter=WIDTH.
  - CALC: one shift-add (mul) or restoring subtract-shift (div) step per cycle; counter decrements. When counter reaches 1, CALC->FIX.
  - FIX (1 cycle): apply sign correction; select low/high product half or quotient/remainder. Load Res/Zero/lt, set done. FIX->IDLE.
  - Timing: done=1 and busy=0 in cycle t+WIDTH+2. The fixed latency is WIDTH+2 for every M op, including special cases.
- Product and divide rules:
  - The product is a full 2*WIDTH-bit value.
  - MULH signed x signed; MULHSU signed A x unsigned B; MULHU unsigned x unsigned; MUL takes the low WIDTH bits.
  - Division truncates toward zero; the remainder takes the sign of the dividend.
- Divide by zero:
  - DIV/DIVU -> all ones.
  - REM/REMU -> A.
- Signed overflow (A = most negative, B = -1):
  - DIV -> A.
  - REM -> 0.
- start while busy=1: ignored, no queuing. Upstream holds start until it sees a cycle with busy=0.
- Back-to-back: start may be high in the cycle done=1. That cycle has busy=0, so the new op is accepted.
- Ctrl is don't-care when start=0. Operand changes after acceptance have no effect.

Decomposition:
- Package alu_pkg:
  - localparams for the 16 Ctrl encodings (base codes equal the legacy 3-bit codes with MSB 0).
  - State enum IDLE/CALC/FIX.
  - Helper function is_unsigned_op(Ctrl) used for lt.
- One natural sub-module, md_iter_core: the unsigned WIDTH-step shift-add/restoring-divide engine with load/step/result ports.
- The top level keeps the FSM, base-op combinational logic, sign handling and output registers.

Test Plan:
- Reset values:
  - Drive rst=1 for 2 cycles -> Res=0, Zero=1, lt=0, busy=0, done=0.
  - After release, SUB A=5 B=5 start -> next cycle done=1, Res=0, Zero=1, lt=0, busy never 1.
- Signed divide (WIDTH=32):
  - DIV A=-7 B=2 -> done exactly 34 cycles after accept, Res=0xFFFFFFFD.
  - REM same operands -> Res=0xFFFFFFFF.
- Multiply high halves (WIDTH=32):
  - MULH 0x80000000*0x80000000 -> 0x40000000.
  - MULHU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE.
  - MULHSU 0xFFFFFFFF*0x00000002 -> 0xFFFFFFFF.
  - MUL 0xFFFFFFFF*0xFFFFFFFF -> 0x00000001.
- Divide special cases (WIDTH=32):
  - DIVU 5/0 -> 0xFFFFFFFF.
  - REMU 5/0 -> 5.
  - DIV 0x80000000/-1 -> 0x80000000.
  - REM 0x80000000/-1 -> 0, Zero=1.
  - All at full latency.
- Handshake:
  - During a DIV, pulse start with SUM -> ignored, Res unchanged until the DIV done.
  - Assert start with SUM A=1 B=2 in the done cycle -> done again next cycle, Res=3.
- Mid-op reset: assert rst at cycle 10 of a MUL -> busy=0 next cycle, no done pulse ever for that MUL. A new MULHU then completes normally.
